pipe_issue_ctrl: RTL
====================

Name: pipe_issue_ctrl

Overview:
Issue controller and arbiter for the 4-stage register-bank ALU/memory pipeline (read, execute, writeback, store). It takes operations {func, rs1, rs2, rd, addr} from two requesters and arbitrates between them round-robin. A scoreboard blocks read-after-write hazards, because the pipeline has no forwarding. The block drives the pipeline's operand/opcode inputs, at most one operation per cycle, and also supports a drain/flush sequence and performance counters.

Parameters:
HAZ_DEPTH, 3, cycles an issued rd stays in flight before its writeback is visible to a new stage-1 read (range 1..7)
NFUNC, 12, number of legal func codes; func >= NFUNC is illegal
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  single pipeline clock, rising edge
rst  in  1  asynchronous, active-high reset
a_valid  in  1  requester A has an operation
a_op  in  24  requester A operation {func[23:20], rs1[19:16], rs2[15:12], rd[11:8], addr[7:0]}
a_ready  out  1  requester A operation accepted this cycle (combinational)
b_valid  in  1  requester B has an operation
b_op  in  24  requester B operation, same packing as a_op
b_ready  out  1  requester B operation accepted this cycle (combinational)
drain  in  1  stop accepting operations and empty the in-flight window
iss_valid  out  1  registered; the iss_* fields hold a new operation this cycle
iss_func  out  4  to pipeline func
iss_rs1  out  4  to pipeline rs1
iss_rs2  out  4  to pipeline rs2
iss_rd  out  4  to pipeline rd
iss_addr  out  8  to pipeline addr
drained  out  1  one-cycle pulse when the drain completes
err_illegal  out  1  one-cycle pulse, one cycle after an illegal func is accepted
issue_cnt  out  CNT_W  number of operations issued, saturating
stall_cnt  out  CNT_W  cycles in which a valid request was blocked by a hazard, saturating

Behaviour:
- Reset (asynchronous, rst=1): all outputs are 0, all scoreboard entries are invalid, state=RUN, round-robin pointer favours A.
- Accept/ready:
  - At most one of a_ready/b_ready is high per cycle.
  - A requester is ready only when: state=RUN, its valid=1, it wins arbitration, and its op is hazard-free.
  - An operation transfers when valid&&ready. A requester must hold its op stable while valid&&!ready.
- Arbitration:
  - If only one requester is valid, that one is the candidate.
  - If both are valid, the candidate is the requester not granted most recently.
  - The pointer updates only on an actual accept.
  - A hazard-blocked candidate blocks issue this cycle. The other requester is NOT considered, so order is preserved per grant.
- Scoreboard:
  - HAZ_DEPTH-entry shift register of {v, rd}, shifted every cycle.
  - A legal accept at cycle N writes entry0 {1, rd}. The entry is valid during cycles N+1 .. N+HAZ_DEPTH, then drops out.
  - Hazard = the candidate's rs1 or rs2 equals the rd of any valid entry. Both sources are always compared, whatever the func.
  - A dependent operation therefore accepts no earlier than N+HAZ_DEPTH+1.
- Issue latency:
  - Accept at cycle N produces iss_valid=1 with the fields at N+1, for exactly one cycle.
  - The iss_* fields hold their last value while iss_valid=0.
- Illegal func:
  - The operation is accepted (ready=1) but is not issued and does not enter the scoreboard.
  - err_illegal pulses at N+1. issue_cnt is unchanged.
- Counters:
  - issue_cnt increments on each legal accept.
  - stall_cnt increments on each cycle in RUN where the candidate exists and is blocked by a hazard.
  - Both saturate at all-ones.
- FSM states: RUN, DRAIN, DONE.
  - RUN -> DRAIN when drain=1 (sampled). No accept occurs in a cycle where drain=1.
  - DRAIN: all ready outputs are 0. Go to DONE when all scoreboard entries are invalid.
  - DONE: drained=1 for this one cycle. Go to RUN if drain=0, otherwise stay in DONE with drained=0.
  - drain while in DONE keeps the block quiescent.
- Simultaneous events:
  - A hazard and drain in the same cycle: drain takes priority; the stall counts as a stall.
  - rst during DRAIN returns to RUN with the scoreboard cleared; no drained pulse.
- Edge cases:
  - rd=0 is an ordinary register; there is no hardwired zero.
  - rs1=rs2=rd in the same op is legal and is not a self-hazard.

Decomposition:
- Package pipe_issue_pkg holds:
  - op field offsets/widths
  - the typedef op_t {func, rs1, rs2, rd, addr}
  - the func code constants (ADD=0 .. SHL=11)
  - NFUNC
  - the state enum {RUN, DRAIN, DONE}
- One sub-module, pipe_scoreboard: the HAZ_DEPTH shift register plus the rs1/rs2 compare. Inputs: push and push_rd. Outputs: hazard and empty.

Test Plan:
- Reset: rst=1 mid-traffic -> all outputs 0 immediately; after release a_ready follows a_valid with no hazards.
- RAW stall:
  - A issues {func=0, rs1=1, rs2=2, rd=3} at N; at N+1 A offers {rs1=3, rs2=4, rd=5}.
  - Required: a_ready=0 for N+1..N+3 and accepted at N+4; stall_cnt=3; iss_rs1=3 at N+5.
- Round-robin: both valid every cycle, independent regs -> grants alternate A,B,A,B; issue_cnt=4 after 4 cycles.
- Blocked winner:
  - B is due but hazarded for 2 cycles while A is valid and clean.
  - Required: no issue for 2 cycles; B issues first, then A.
- Illegal func: A sends func=13 -> a_ready=1, iss_valid stays 0, err_illegal pulse at the next cycle, scoreboard unchanged.
- Drain:
  - Issue rd=7, then assert drain on the next cycle.
  - Required: no ready outputs; drained pulses exactly once, at issue+HAZ_DEPTH+1. Releasing drain resumes acceptance in the next cycle.

Source files
------------

// File: rtl/pipe_issue_pkg.sv
// Shared definitions for the pipeline issue controller.
// Holds the operation field layout, the op_t record, the func code names,
// the count of legal func codes and the controller state enum.
package pipe_issue_pkg;

    // Operation word layout: {func, rs1, rs2, rd, addr}
    localparam int unsigned OP_W     = 24;
    localparam int unsigned FUNC_W   = 4;
    localparam int unsigned REG_W    = 4;
    localparam int unsigned ADDR_W   = 8;
    localparam int unsigned FUNC_LSB = 20;
    localparam int unsigned RS1_LSB  = 16;
    localparam int unsigned RS2_LSB  = 12;
    localparam int unsigned RD_LSB   = 8;
    localparam int unsigned ADDR_LSB = 0;

    // Func codes 0 .. NFUNC-1 are legal; anything above is rejected
    localparam int unsigned NFUNC = 12;

    typedef enum logic [FUNC_W-1:0] {
        FUNC_ADD = 4'd0,
        FUNC_SUB = 4'd1,
        FUNC_AND = 4'd2,
        FUNC_OR  = 4'd3,
        FUNC_XOR = 4'd4,
        FUNC_NOT = 4'd5,
        FUNC_LD  = 4'd6,
        FUNC_ST  = 4'd7,
        FUNC_MOV = 4'd8,
        FUNC_CMP = 4'd9,
        FUNC_SHR = 4'd10,
        FUNC_SHL = 4'd11
    } func_e;

    // func kept as raw bits so that illegal codes can be represented
    typedef struct packed {
        logic [FUNC_W-1:0] func;
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
        logic [REG_W-1:0]  rd;
        logic [ADDR_W-1:0] addr;
    } op_t;

    typedef enum logic [1:0] {
        StRun,
        StDrain,
        StDone
    } state_e;

    function automatic op_t unpack_op(input logic [OP_W-1:0] raw);
        op_t op;
        op.func = raw[FUNC_LSB +: FUNC_W];
        op.rs1  = raw[RS1_LSB +: REG_W];
        op.rs2  = raw[RS2_LSB +: REG_W];
        op.rd   = raw[RD_LSB +: REG_W];
        op.addr = raw[ADDR_LSB +: ADDR_W];
        return op;
    endfunction

    function automatic logic func_legal(input logic [FUNC_W-1:0] func,
                                        input int unsigned      nfunc);
        return 32'(func) < nfunc;
    endfunction

endpackage

// File: rtl/pipe_scoreboard.sv
// RAW hazard scoreboard for the issue controller.
// A HAZ_DEPTH-deep shift register of {valid, rd}, shifted every cycle. A push
// at cycle N makes the rd visible for cycles N+1 .. N+HAZ_DEPTH.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   push      record push_rd as in flight this cycle
//   push_rd   destination register of the accepted op
//   rs1, rs2  source registers of the current issue candidate
//   hazard    either source matches a valid in-flight rd
//   empty     no valid entries remain
module pipe_scoreboard
    import pipe_issue_pkg::*;
#(
    parameter int unsigned HAZ_DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [REG_W-1:0] push_rd,
    input  logic [REG_W-1:0] rs1,
    input  logic [REG_W-1:0] rs2,
    output logic             hazard,
    output logic             empty
);

    logic [HAZ_DEPTH-1:0] v_q;
    logic [REG_W-1:0]     rd_q [HAZ_DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= '0;
            for (int i = 0; i < int'(HAZ_DEPTH); i++) begin
                rd_q[i] <= '0;
            end
        end else begin
            for (int i = int'(HAZ_DEPTH) - 1; i > 0; i--) begin
                v_q[i]  <= v_q[i-1];
                rd_q[i] <= rd_q[i-1];
            end
            v_q[0]  <= push;
            rd_q[0] <= push_rd;
        end
    end

    // Both sources are compared regardless of func; a spurious stall on an
    // unused source is cheaper than decoding operand usage per func.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < int'(HAZ_DEPTH); i++) begin
            if (v_q[i] && ((rd_q[i] == rs1) || (rd_q[i] == rs2))) begin
                hazard = 1'b1;
            end
        end
    end

    assign empty = ~|v_q;

endmodule

// File: rtl/pipe_issue_ctrl.sv
// Issue controller for the 4-stage read/execute/writeback/store pipeline.
// Arbitrates round-robin between requesters A and B, holds back ops whose
// sources are still being written (no forwarding in the pipeline), issues at
// most one op per cycle, supports a drain handshake and keeps saturating
// issue/stall counters.
// Ports:
//   clk, rst                 clock and asynchronous active-high reset
//   a_valid/a_op/a_ready     requester A handshake (ready is combinational)
//   b_valid/b_op/b_ready     requester B handshake (ready is combinational)
//   drain                    stop accepting and wait for the window to empty
//   iss_valid, iss_*         registered issue port to the pipeline
//   drained                  one-cycle pulse when a drain completes
//   err_illegal              one-cycle pulse after an illegal func is accepted
//   issue_cnt, stall_cnt     saturating performance counters
module pipe_issue_ctrl #(
    parameter int unsigned HAZ_DEPTH = 3,
    parameter int unsigned NFUNC     = pipe_issue_pkg::NFUNC,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [23:0]      a_op,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [23:0]      b_op,
    output logic             b_ready,
    input  logic             drain,
    output logic             iss_valid,
    output logic [3:0]       iss_func,
    output logic [3:0]       iss_rs1,
    output logic [3:0]       iss_rs2,
    output logic [3:0]       iss_rd,
    output logic [7:0]       iss_addr,
    output logic             drained,
    output logic             err_illegal,
    output logic [CNT_W-1:0] issue_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    import pipe_issue_pkg::*;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e state_q, state_d;

    op_t  a_rec, b_rec, cand_op, iss_op_q;
    logic prio_b_q;
    logic cand_a, cand_b, cand_valid;
    logic sb_hazard, sb_empty;
    logic accept_ok, accept, legal, push, stall_evt;
    logic iss_valid_q, err_q, drained_q, drained_d;
    logic [CNT_W-1:0] issue_cnt_q, stall_cnt_q;

    assign a_rec = unpack_op(a_op);
    assign b_rec = unpack_op(b_op);

    // Candidate selection. prio_b_q is set after A is granted, so with both
    // valid the requester not granted last goes next. A blocked candidate is
    // not bypassed, which keeps the grant order fixed.
    always_comb begin
        cand_a     = a_valid && (!b_valid || !prio_b_q);
        cand_b     = b_valid && !cand_a;
        cand_valid = cand_a || cand_b;
        cand_op    = cand_b ? b_rec : a_rec;
    end

    pipe_scoreboard #(
        .HAZ_DEPTH (HAZ_DEPTH)
    ) u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .push_rd (cand_op.rd),
        .rs1     (cand_op.rs1),
        .rs2     (cand_op.rs2),
        .hazard  (sb_hazard),
        .empty   (sb_empty)
    );

    // rst gates readiness so every output reads 0 while reset is asserted
    always_comb begin
        accept_ok = !rst && (state_q == StRun) && !drain && cand_valid && !sb_hazard;
        a_ready   = accept_ok && cand_a;
        b_ready   = accept_ok && cand_b;
        accept    = a_ready || b_ready;
        legal     = func_legal(cand_op.func, NFUNC);
        push      = accept && legal;
        // A hazard stall counts even when drain blocks acceptance this cycle
        stall_evt = (state_q == StRun) && cand_valid && sb_hazard;
    end

    always_comb begin
        state_d   = state_q;
        drained_d = 1'b0;
        unique case (state_q)
            StRun: begin
                if (drain) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (sb_empty) begin
                    state_d   = StDone;
                    drained_d = 1'b1;
                end
            end
            StDone: begin
                if (!drain) begin
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StRun;
            prio_b_q    <= 1'b0;
            iss_valid_q <= 1'b0;
            iss_op_q    <= '0;
            err_q       <= 1'b0;
            drained_q   <= 1'b0;
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drained_q   <= drained_d;
            iss_valid_q <= push;
            err_q       <= accept && !legal;
            if (accept) begin
                prio_b_q <= cand_a;
            end
            // Fields hold their last issued value while iss_valid is low
            if (push) begin
                iss_op_q <= cand_op;
            end
            if (push && !(&issue_cnt_q)) begin
                issue_cnt_q <= issue_cnt_q + CNT_ONE;
            end
            if (stall_evt && !(&stall_cnt_q)) begin
                stall_cnt_q <= stall_cnt_q + CNT_ONE;
            end
        end
    end

    assign iss_valid   = iss_valid_q;
    assign iss_func    = iss_op_q.func;
    assign iss_rs1     = iss_op_q.rs1;
    assign iss_rs2     = iss_op_q.rs2;
    assign iss_rd      = iss_op_q.rd;
    assign iss_addr    = iss_op_q.addr;
    assign drained     = drained_q;
    assign err_illegal = err_q;
    assign issue_cnt   = issue_cnt_q;
    assign stall_cnt   = stall_cnt_q;

endmodule
